// File: rtl/vx_alu_dotn.sv
// vx_alu_dotn: multi-format packed dot-product PE with a stall-able LATENCY-deep pipeline
module vx_alu_dotn #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int TAG_W     = 8,
  parameter int LATENCY   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic                      in_signed,
  input  logic                      in_accum,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [NUM_LANES-1:0]      in_mask,
  input  logic [NUM_LANES*XLEN-1:0] in_rs1,
  input  logic [NUM_LANES*XLEN-1:0] in_rs2,
  input  logic [NUM_LANES*XLEN-1:0] in_rs3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [TAG_W-1:0]          out_tag,
  output logic [NUM_LANES-1:0]      out_mask,
  output logic [NUM_LANES*XLEN-1:0] out_data,
  output logic                      busy,
  output logic [31:0]               perf_ops
);
  localparam int P = LATENCY > 1 ? LATENCY - 1 : 1;
  localparam int S = P - 1;
  typedef logic [NUM_LANES-1:0][7:0][31:0] prod_t;
  typedef logic [NUM_LANES-1:0][31:0] word_t;
  logic [LATENCY-1:0] v;
  logic [TAG_W-1:0] tag_q [LATENCY];
  logic [NUM_LANES-1:0] mask_q [LATENCY];
  logic [1:0] mode_q [P];
  logic [P-1:0] sgn_q, acc_q;
  word_t rs3_q [P];
  prod_t prod_q [P];
  prod_t prod_in, prod_r;
  word_t rs3_in, rs3_r;
  logic [1:0] mode_r;
  logic sgn_r, acc_r, stall;
  logic [NUM_LANES-1:0] mask_r;
  logic [NUM_LANES*XLEN-1:0] res_in;
  function automatic logic [7:0][31:0] prods(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] m, input logic s);
    logic [7:0][31:0] p;
    p = '0;
    if (m == 2'd0)
      for (int i = 0; i < 4; i++)
        p[i] = {{24{s & a[8*i+7]}}, a[8*i +: 8]} * {{24{s & b[8*i+7]}}, b[8*i +: 8]};
    if (m == 2'd1)
      for (int i = 0; i < 8; i++)
        p[i] = {{28{s & a[4*i+3]}}, a[4*i +: 4]} * {{28{s & b[4*i+3]}}, b[4*i +: 4]};
    if (m == 2'd2)
      for (int i = 0; i < 2; i++)
        p[i] = {{16{s & a[16*i+15]}}, a[16*i +: 16]} * {{16{s & b[16*i+15]}}, b[16*i +: 16]};
    return p;
  endfunction
  function automatic logic [XLEN-1:0] reduce(input logic [7:0][31:0] p, input logic [31:0] c,
                                             input logic [1:0] m, input logic s,
                                             input logic acc, input logic k);
    logic [31:0] sum;
    logic signed [XLEN-1:0] se;
    sum = acc ? c : 32'd0;
    for (int i = 0; i < 8; i++) sum = sum + p[i];
    sum = (m == 2'd3 || !k) ? 32'd0 : sum;
    se = XLEN'($signed(sum));
    return s ? se : XLEN'(sum);
  endfunction
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];
  assign out_mask  = mask_q[LATENCY-1];
  assign busy      = |v;
  assign prod_r    = LATENCY == 1 ? prod_in : prod_q[S];
  assign rs3_r     = LATENCY == 1 ? rs3_in : rs3_q[S];
  assign mode_r    = LATENCY == 1 ? in_mode : mode_q[S];
  assign sgn_r     = LATENCY == 1 ? in_signed : sgn_q[S];
  assign acc_r     = LATENCY == 1 ? in_accum : acc_q[S];
  assign mask_r    = LATENCY == 1 ? in_mask : mask_q[S];
  // stage-0 multipliers: per-lane sub-word products from the raw operands
  always_comb begin
    prod_in = '0;
    rs3_in  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      rs3_in[l]  = in_rs3[l*XLEN +: 32];
      prod_in[l] = prods(in_rs1[l*XLEN +: 32], in_rs2[l*XLEN +: 32], in_mode, in_signed);
    end
  end
  // final-stage reduction tree, accumulate, masking and XLEN extension
  always_comb begin
    res_in = '0;
    for (int l = 0; l < NUM_LANES; l++)
      res_in[l*XLEN +: XLEN] = reduce(prod_r[l], rs3_r[l], mode_r, sgn_r, acc_r, mask_r[l]);
  end
  // pipeline registers: every stage advances together unless the output is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      v        <= '0;
      sgn_q    <= '0;
      acc_q    <= '0;
      perf_ops <= '0;
      out_data <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k]  <= '0;
        mask_q[k] <= '0;
      end
      for (int k = 0; k < P; k++) begin
        mode_q[k] <= '0;
        rs3_q[k]  <= '0;
        prod_q[k] <= '0;
      end
    end else if (!stall) begin
      v[0] <= in_valid;
      for (int k = 1; k < LATENCY; k++) begin
        v[k]      <= v[k-1];
        tag_q[k]  <= tag_q[k-1];
        mask_q[k] <= mask_q[k-1];
      end
      for (int k = 1; k < P; k++) begin
        mode_q[k] <= mode_q[k-1];
        sgn_q[k]  <= sgn_q[k-1];
        acc_q[k]  <= acc_q[k-1];
        rs3_q[k]  <= rs3_q[k-1];
        prod_q[k] <= prod_q[k-1];
      end
      if (in_valid) begin
        tag_q[0]  <= in_tag;
        mask_q[0] <= in_mask;
        mode_q[0] <= in_mode;
        sgn_q[0]  <= in_signed;
        acc_q[0]  <= in_accum;
        rs3_q[0]  <= rs3_in;
        prod_q[0] <= prod_in;
        perf_ops  <= perf_ops + 32'd1;
      end
      if (LATENCY > 1 || in_valid) out_data <= res_in;
    end
  end
endmodule

// File: tb/tb_vx_alu_dotn.sv
// tb_vx_alu_dotn: directed self-checking bench for the packed dot-product PE
module tb_vx_alu_dotn;
  localparam int NL = 4, XL = 64, TW = 8, LAT = 3;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_signed = 1'b0, in_accum = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [1:0] in_mode = 2'd0;
  logic [TW-1:0] in_tag = '0, out_tag;
  logic [NL-1:0] in_mask = '0, out_mask;
  logic [NL-1:0][XL-1:0] rs1 = '0, rs2 = '0, rs3 = '0, out_data, exp_d;
  logic [31:0] perf_ops;
  int total = 0, bad = 0, ops = 0, n = 0;
  int sent = 0, got = 0, cyc = 0;
  logic pstall = 1'b0;
  logic [TW-1:0] ptag = '0;
  logic [XL-1:0] pd = '0;

  vx_alu_dotn #(.NUM_LANES(NL), .XLEN(XL), .TAG_W(TW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_signed(in_signed), .in_accum(in_accum), .in_tag(in_tag), .in_mask(in_mask),
    .in_rs1(rs1), .in_rs2(rs2), .in_rs3(rs3), .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_mask(out_mask), .out_data(out_data), .busy(busy), .perf_ops(perf_ops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] m, input logic s, input logic a,
                      input logic [TW-1:0] t, input logic [NL-1:0] mk);
    in_mode = m; in_signed = s; in_accum = a; in_tag = t; in_mask = mk; in_valid = 1'b1;
    #1;
    chk("send_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    ops++;
  endtask

  task automatic expect_out(input string name, input logic [TW-1:0] t, input logic [NL-1:0] mk);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({name, "_latency"}, 64'(n), 64'(LAT - 1));
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_tag"}, 64'(out_tag), 64'(t));
    chk({name, "_mask"}, 64'(out_mask), 64'(mk));
    for (int l = 0; l < NL; l++) chk($sformatf("%s_lane%0d", name, l), out_data[l], exp_d[l]);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_perf_ops", 64'(perf_ops), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_mask", 64'(out_mask), 64'd0);
    for (int l = 0; l < NL; l++) chk("rst_out_data", out_data[l], 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    step();
    rs1 = {64'h0, 64'h7F7F7F7F, 64'h01010101, 64'hDEADBEEF_FF02FF02};
    rs1[3] = 64'h00000080;
    rs2 = {64'h00000002, 64'h7F7F7F7F, 64'h01020304, 64'h12345678_7F037F03};
    rs3 = {4{64'h55555555_55555555}};
    exp_d = {64'hFFFFFFFF_FFFFFF00, 64'h0000FC04, 64'h0000000A, 64'hFFFFFFFF_FFFFFF0E};
    send(2'd0, 1'b1, 1'b0, 8'h11, 4'hF);
    chk("t1_busy", 64'(busy), 64'd1);
    expect_out("t1_s8", 8'h11, 4'hF);
    exp_d = {64'h00000100, 64'h0000FC04, 64'h0000000A, 64'h0000FD0E};
    send(2'd0, 1'b0, 1'b0, 8'h12, 4'hF);
    expect_out("t1_u8", 8'h12, 4'hF);
    exp_d = {64'hFFFFFFFF_FFFFFF00, 64'h0, 64'h0000000A, 64'h0};
    send(2'd0, 1'b1, 1'b0, 8'h13, 4'b1010);
    expect_out("mask_s8", 8'h13, 4'b1010);
    rs1 = {4{64'hA5A5A5A5_FFFFFFFF}};
    rs2 = {4{64'h00000000_FFFFFFFF}};
    rs3 = {64'hFFFFFFFF_0000000A, 64'hFFFFFFFF_0000000A, 64'h0, 64'hFFFFFFFF_0000000A};
    exp_d = {64'h712, 64'h712, 64'h708, 64'h712};
    send(2'd1, 1'b0, 1'b1, 8'h21, 4'hF);
    expect_out("t2_u4", 8'h21, 4'hF);
    exp_d = {64'h12, 64'h12, 64'h8, 64'h12};
    send(2'd1, 1'b1, 1'b1, 8'h22, 4'hF);
    expect_out("t2_s4", 8'h22, 4'hF);
    rs1 = {64'h80008000, 64'h00027FFF, 64'h80008000, 64'h80008000};
    rs2 = {64'h80008000, 64'h0003FFFF, 64'h80008000, 64'h80008000};
    rs3 = '0;
    exp_d = {64'hFFFFFFFF_80000000, 64'hFFFFFFFF_FFFF8007, 64'hFFFFFFFF_80000000, 64'hFFFFFFFF_80000000};
    send(2'd2, 1'b1, 1'b0, 8'h31, 4'hF);
    expect_out("t3_s16", 8'h31, 4'hF);
    exp_d = {64'h80000000, 64'h7FFE8007, 64'h80000000, 64'h80000000};
    send(2'd2, 1'b0, 1'b0, 8'h32, 4'hF);
    expect_out("t3_u16", 8'h32, 4'hF);
    rs1 = {64'h7F7F7F7F, 64'h7F7F7F7F, 64'h0, 64'h7F7F7F7F};
    rs2 = rs1;
    rs3 = {64'hFFFFFFFF, 64'hFFFFFFFF, 64'h80000000, 64'hFFFFFFFF};
    exp_d = {64'hFC03, 64'hFC03, 64'hFFFFFFFF_80000000, 64'hFC03};
    send(2'd0, 1'b1, 1'b1, 8'h33, 4'hF);
    expect_out("acc_wrap", 8'h33, 4'hF);
    rs3 = {4{64'h5}};
    exp_d = '0;
    send(2'd3, 1'b1, 1'b1, 8'h5A, 4'b0101);
    expect_out("t5_mode3", 8'h5A, 4'b0101);
    step();
    chk("perf_directed", 64'(perf_ops), 64'(ops));
    in_mode = 2'd0; in_signed = 1'b0; in_accum = 1'b0; in_mask = 4'hF; rs3 = '0;
    rs2 = {4{64'h3}};
    while (got < 16 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      in_valid = sent < 16;
      in_tag = 8'(64 + sent);
      rs1 = {4{64'(sent)}};
      #1;
      chk("t4_in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (pstall) begin
        chk("t4_hold_tag", 64'(out_tag), 64'(ptag));
        chk("t4_hold_data", out_data[0], pd);
      end
      if (out_valid && out_ready) begin
        chk("t4_tag", 64'(out_tag), 64'(64 + got));
        chk("t4_data", out_data[3], 64'(3 * got));
        got++;
      end
      if (in_valid && in_ready) begin
        sent++;
        ops++;
      end
      pstall = out_valid && !out_ready;
      ptag = out_tag;
      pd = out_data[0];
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("t4_retired", 64'(got), 64'd16);
    chk("t4_perf_ops", 64'(perf_ops), 64'(ops));
    step();
    chk("t4_drained", 64'(busy), 64'd0);
    rs1 = {4{64'h01010101}};
    rs2 = {4{64'h01010101}};
    send(2'd0, 1'b0, 1'b0, 8'h71, 4'hF);
    send(2'd0, 1'b0, 1'b0, 8'h72, 4'hF);
    chk("t6_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    step();
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_busy_rst", 64'(busy), 64'd0);
    chk("t6_perf_ops", 64'(perf_ops), 64'd0);
    chk("t6_out_data", out_data[0], 64'd0);
    reset = 1'b0;
    ops = 0;
    #1;
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t6_no_stale", 64'(out_valid), 64'd0);
    end
    exp_d = {4{64'h4}};
    send(2'd0, 1'b0, 1'b0, 8'h73, 4'hF);
    expect_out("t6_recover", 8'h73, 4'hF);
    chk("t6_perf_after", 64'(perf_ops), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
